// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable synchronized
// LOCKED flag, then releases the reset for logic in the PLL clock domains.
// A missing lock is retried a bounded number of times before a latched fault.
// A lock loss during normal operation restarts the sequence and is counted.
module pll_lock_supervisor #(
    parameter int unsigned RESET_PULSE_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    output logic       o_pll_reset,
    output logic       o_sys_rst_n,
    output logic       o_fault,
    output logic [2:0] o_state,
    output logic [7:0] o_lock_loss_count
);

    localparam int unsigned MAX_AB = (RESET_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RESET_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ?
                                     MAX_AB : LOCK_STABLE_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          sync1_q, sync2_q;
    logic          lock_s;

    // Two-flop synchronizer for the asynchronous LOCKED flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_pll_locked;
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q;

    // State, shared phase counter, retry count and loss count registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_PLL_RESET;
            cnt_q   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state logic; one counter serves as pulse, timeout and stability
    // counter since only one of those phases is ever active, and it is
    // cleared on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            S_PLL_RESET: begin
                if (cnt_q == RESET_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_PLL_RESET;
                    end else begin
                        state_d = S_FAULT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_PLL_RESET;
                    cnt_d   = '0;
                    retry_d = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_PLL_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded only from registered state
    always_comb begin
        o_pll_reset       = (state_q == S_PLL_RESET) || (state_q == S_FAULT);
        o_sys_rst_n       = (state_q == S_RUN);
        o_fault           = (state_q == S_FAULT);
        o_state           = state_q;
        o_lock_loss_count = loss_q;
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters
// (pulse 4, timeout 32, stable 8, 2 retries).
module tb_pll_lock_supervisor;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       fault;
    logic [2:0] state;
    logic [7:0] loss_cnt;

    int vectors;
    int miscompares;

    pll_lock_supervisor #(
        .RESET_PULSE_CYCLES (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_pll_locked     (locked),
        .o_pll_reset      (pll_reset),
        .o_sys_rst_n      (sys_rst_n),
        .o_fault          (fault),
        .o_state          (state),
        .o_lock_loss_count(loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk1({tag, "_pll_reset"}, pll_reset, 1'b1);
        chk1({tag, "_sys_rst_n"}, sys_rst_n, 1'b0);
        chk1({tag, "_fault"}, fault, 1'b0);
        chk8({tag, "_state"}, {5'd0, state}, 8'd0);
        chk8({tag, "_loss"}, loss_cnt, 8'd0);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int i;
        i = 0;
        while (state !== s && i < budget) begin
            tick();
            i++;
        end
        chk8(tag, {5'd0, state}, {5'd0, s});
    endtask

    initial begin
        int   nfalls;
        int   highs;
        int   fall_at[3];
        logic prev;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        locked      = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_values("por");

        // Nominal bring-up: 4-cycle pulse after release
        rst_n = 1'b1;
        repeat (3) tick();
        chk1("pulse_hold_3", pll_reset, 1'b1);
        chk8("pulse_state_3", {5'd0, state}, 8'd0);
        tick();
        chk1("pulse_end_4", pll_reset, 1'b0);
        chk8("wait_state_4", {5'd0, state}, 8'd1);
        repeat (6) tick();
        locked = 1'b1;
        tick();
        tick();
        chk8("sync_delay_2", {5'd0, state}, 8'd1);
        tick();
        chk8("stable_entry_3", {5'd0, state}, 8'd2);
        repeat (7) tick();
        chk8("stable_10", {5'd0, state}, 8'd2);
        chk1("sysrst_low_10", sys_rst_n, 1'b0);
        tick();
        chk8("run_11", {5'd0, state}, 8'd3);
        chk1("sysrst_high_11", sys_rst_n, 1'b1);
        chk1("run_pll_reset", pll_reset, 1'b0);
        chk1("run_fault", fault, 1'b0);
        chk8("run_loss0", loss_cnt, 8'd0);

        // Lock loss in RUN
        locked = 1'b0;
        tick();
        tick();
        chk1("loss_edge2_sys", sys_rst_n, 1'b1);
        tick();
        chk1("loss_edge3_sys", sys_rst_n, 1'b0);
        chk1("loss_edge3_pll", pll_reset, 1'b1);
        chk8("loss_count1", loss_cnt, 8'd1);
        repeat (3) tick();
        chk1("loss_pulse_hold", pll_reset, 1'b1);
        tick();
        chk1("loss_pulse_end", pll_reset, 1'b0);
        chk8("loss_wait", {5'd0, state}, 8'd1);
        locked = 1'b1;
        repeat (11) tick();
        chk8("relock_run", {5'd0, state}, 8'd3);
        chk8("relock_loss1", loss_cnt, 8'd1);

        // Glitch during STABLE: get back to STABLE first
        locked = 1'b0;
        repeat (7) tick();
        chk8("glitch_prep_wait", {5'd0, state}, 8'd1);
        locked = 1'b1;
        repeat (3) tick();
        chk8("glitch_prep_stable", {5'd0, state}, 8'd2);
        repeat (4) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        chk8("glitch_a", {5'd0, state}, 8'd2);
        tick();
        chk8("glitch_a1", {5'd0, state}, 8'd2);
        tick();
        chk8("glitch_back_wait", {5'd0, state}, 8'd1);
        chk1("glitch_no_pulse", pll_reset, 1'b0);
        tick();
        chk8("glitch_restable", {5'd0, state}, 8'd2);
        repeat (7) tick();
        chk1("glitch_sys_10", sys_rst_n, 1'b0);
        chk1("glitch_no_pulse2", pll_reset, 1'b0);
        tick();
        chk1("glitch_sys_11", sys_rst_n, 1'b1);
        chk8("glitch_loss2", loss_cnt, 8'd2);

        // Asynchronous reset while in RUN
        rst_n = 1'b0;
        #1;
        chk_reset_values("rst_in_run");

        // Lock never arrives
        locked = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        prev   = pll_reset;
        highs  = pll_reset ? 1 : 0;
        nfalls = 0;
        for (int n = 1; n <= 107; n++) begin
            tick();
            if (prev && !pll_reset) begin
                if (nfalls < 3) fall_at[nfalls] = n;
                nfalls++;
            end
            if (pll_reset) highs++;
            prev = pll_reset;
        end
        chk8("nolock_pulses", 8'(nfalls), 8'd3);
        chk8("nolock_high_cycles", 8'(highs), 8'd12);
        chk8("nolock_fall0", 8'(fall_at[0]), 8'd4);
        chk8("nolock_fall1", 8'(fall_at[1]), 8'd40);
        chk8("nolock_fall2", 8'(fall_at[2]), 8'd76);
        chk8("nolock_last_wait", {5'd0, state}, 8'd1);
        tick();
        chk8("fault_state", {5'd0, state}, 8'd4);
        chk1("fault_flag", fault, 1'b1);
        chk1("fault_pll", pll_reset, 1'b1);
        chk1("fault_sys", sys_rst_n, 1'b0);
        locked = 1'b1;
        repeat (40) tick();
        chk8("fault_absorb", {5'd0, state}, 8'd4);
        chk1("fault_absorb_pll", pll_reset, 1'b1);

        // Asynchronous reset while in FAULT
        rst_n = 1'b0;
        #1;
        chk_reset_values("rst_in_fault");

        // Timeout coincides with lock arrival: lock wins
        locked = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (33) tick();
        locked = 1'b1;
        repeat (2) tick();
        chk8("coinc_35", {5'd0, state}, 8'd1);
        tick();
        chk8("coinc_36", {5'd0, state}, 8'd2);
        chk1("coinc_no_pulse", pll_reset, 1'b0);
        wait_state(3'd3, 20, "coinc_run");

        // Loss counter saturation
        for (int k = 1; k <= 257; k++) begin
            locked = 1'b0;
            repeat (3) tick();
            locked = 1'b1;
            wait_state(3'd3, 40, "sat_relock");
            if (k == 1) chk8("sat_first", loss_cnt, 8'd1);
            if (k == 255) chk8("sat_255", loss_cnt, 8'd255);
        end
        chk8("sat_hold", loss_cnt, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
